// File: rtl/alu_op_stage.sv
// alu_op_stage: registered issue/execute ALU stage with valid/ready handshake
module alu_op_stage #(
  parameter int size = 8,
  parameter int cntw = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [size-1:0] c,
  output logic            zero,
  output logic            carry,
  output logic            ovf,
  output logic            busy,
  output logic [cntw-1:0] ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state;
  logic [2:0] rop;
  logic [size-1:0] ra, rb, res;
  logic [size:0] sum, dif;
  logic cy, ov;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  // ALU evaluated on the latched operands; the extra MSB of sum/dif is carry/borrow
  always_comb begin
    sum = {1'b0, ra} + {1'b0, rb};
    dif = {1'b0, ra} - {1'b0, rb};
    res = rop == 3'd0 ? ra & rb :
          rop == 3'd1 ? ra | rb :
          rop == 3'd2 ? ra ^ rb :
          rop == 3'd3 ? sum[size-1:0] :
          rop == 3'd4 ? dif[size-1:0] :
          rop == 3'd5 ? ~ra :
          rop == 3'd6 ? {ra[size-2:0], 1'b0} : ra;
    cy = rop == 3'd3 ? sum[size] :
         rop == 3'd4 ? dif[size] :
         rop == 3'd6 ? ra[size-1] : 1'b0;
    ov = rop == 3'd3 ? (ra[size-1] == rb[size-1]) && (sum[size-1] != ra[size-1]) :
         rop == 3'd4 ? (ra[size-1] != rb[size-1]) && (dif[size-1] != ra[size-1]) : 1'b0;
  end
  // FSM: accept in IDLE, compute in EXEC, hold the result in DONE until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rop <= '0;
      ra <= '0;
      rb <= '0;
      c <= '0;
      zero <= 1'b0;
      carry <= 1'b0;
      ovf <= 1'b0;
      out_valid <= 1'b0;
      ops_done <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          rop <= op;
          ra <= a;
          rb <= b;
          state <= EXEC;
        end
        EXEC: begin
          c <= res;
          zero <= res == '0;
          carry <= cy;
          ovf <= ov;
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          ops_done <= ops_done + cntw'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_stage.sv
// tb_alu_op_stage: directed scoreboard bench for alu_op_stage
module tb_alu_op_stage;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [2:0] op = 0;
  logic [7:0] a = 0, b = 0, c;
  logic in_ready, out_valid, zero, carry, ovf, busy;
  logic [3:0] ops_done, exp_cnt;
  logic [10:0] sb[$];
  logic [10:0] exp_r;
  int total = 0, bad = 0, cyc = 0, acc = 0, acc_prev = 0;

  alu_op_stage #(.size(8), .cntw(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .zero(zero), .carry(carry), .ovf(ovf), .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // reference: {c, zero, carry, ovf} from integer arithmetic
  function automatic logic [10:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int ux, uy, sx, sy, r, sr;
    logic [7:0] rc;
    logic cf, of;
    ux = x; uy = y; sx = $signed(x); sy = $signed(y);
    cf = 0; of = 0;
    case (o)
      3'd0: r = ux & uy;
      3'd1: r = ux | uy;
      3'd2: r = ux ^ uy;
      3'd3: begin r = ux + uy; cf = r > 255; sr = sx + sy; of = sr > 127 || sr < -128; end
      3'd4: begin r = ux - uy; cf = ux < uy; sr = sx - sy; of = sr > 127 || sr < -128; end
      3'd5: r = 255 - ux;
      3'd6: begin r = ux * 2; cf = ux >= 128; end
      default: r = ux;
    endcase
    rc = r[7:0];
    return {rc, rc == 0, cf, of};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // one transaction: accept, check EXEC, check result, optional backpressure, handoff
  task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input int hold, input bit pulse);
    int n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("ready_wait", in_ready, 1);
    op = o; a = x; b = y; in_valid = 1; out_ready = (hold == 0);
    sb.push_back(model(o, x, y));
    @(posedge clk);
    acc_prev = acc; acc = cyc;
    @(negedge clk);
    in_valid = 0; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
    chk("exec_valid", out_valid, 0);
    chk("exec_busy", busy, 1);
    chk("exec_ready", in_ready, 0);
    @(negedge clk);
    chk("done_valid", out_valid, 1);
    exp_r = sb.pop_front();
    chk("result", {c, zero, carry, ovf}, exp_r);
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == 1) begin in_valid = 1; op = 0; a = 0; b = 0; end
      else in_valid = 0;
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_stable", {c, zero, carry, ovf}, exp_r);
      chk("hold_ready", in_ready, 0);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    exp_cnt = exp_cnt + 1;
    chk("handoff_valid", out_valid, 0);
    chk("ops_done", ops_done, exp_cnt);
    chk("idle_ready", in_ready, 1);
    chk("c_held", c, exp_r[10:3]);
  endtask

  initial begin
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_c", c, 0);
    chk("rst_flags", {zero, carry, ovf}, 0);
    chk("rst_cnt", ops_done, 0);
    chk("rst_busy", busy, 0);
    issue(3'd1, 8'hA5, 8'h5A, 0, 0);
    chk("or_c", c, 8'hFF);
    issue(3'd3, 8'hFF, 8'h01, 0, 0);
    chk("add_wrap", {c, zero, carry, ovf}, {8'h00, 3'b110});
    issue(3'd3, 8'h7F, 8'h01, 0, 0);
    chk("add_ovf", {c, zero, carry, ovf}, {8'h80, 3'b001});
    issue(3'd4, 8'h10, 8'h20, 0, 0);
    chk("sub_borrow", {c, zero, carry, ovf}, {8'hF0, 3'b010});
    issue(3'd4, 8'h80, 8'h01, 0, 0);
    chk("sub_ovf", {c, zero, carry, ovf}, {8'h7F, 3'b001});
    issue(3'd0, 8'hC3, 8'h96, 0, 0);
    issue(3'd5, 8'h0F, 8'h00, 0, 0);
    issue(3'd7, 8'h00, 8'hAA, 0, 0);
    issue(3'd2, 8'h3C, 8'h0F, 5, 1);
    chk("bp_c", c, 8'h33);
    @(negedge clk);
    chk("bp_no_ghost", busy, 0);
    chk("bp_no_ghost_v", out_valid, 0);
    op = 3'd6; a = 8'h81; b = 0; in_valid = 1; out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; rst_n = 0;
    @(negedge clk);
    chk("mid_valid", out_valid, 0);
    chk("mid_ready", in_ready, 1);
    chk("mid_busy", busy, 0);
    chk("mid_c", {c, zero, carry, ovf}, 0);
    chk("mid_cnt", ops_done, 0);
    rst_n = 1; exp_cnt = 0;
    @(negedge clk);
    chk("mid_idle_valid", out_valid, 0);
    issue(3'd6, 8'h81, 8'h00, 0, 0);
    chk("shl", {c, carry}, {8'h02, 1'b1});
    rst_n = 0;
    @(negedge clk);
    rst_n = 1; exp_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      issue(3'd1, 8'($urandom), 8'($urandom), 0, 0);
      if (i > 0) chk("interval", acc - acc_prev, 3);
    end
    chk("wrap", ops_done, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
